// File: rtl/l3_mlp_pkg.sv
// l3_mlp_pkg: shared types and helpers for the serial MLP engine.
// Contents: FSM state enum, accumulator width, weight RAM address map,
// saturation to a signed word, and ReLU clamp.
package l3_mlp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LOAD,
        S_MAC,
        S_FIN,
        S_OUT,
        S_DONE
    } state_t;

    // Products are 2*w bits; summing up to n of them plus headroom for the bias.
    function automatic int acc_width(input int w, input int n);
        return 2 * w + $clog2(n + 1);
    endfunction

    // Weight word for layer l (1-based), neuron j, input i; i == n is the bias.
    function automatic int cfg_addr(input int l, input int j, input int i, input int n);
        return ((l - 1) * n + j) * (n + 1) + i;
    endfunction

    function automatic longint sat_w(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction

    function automatic longint relu_clamp(input longint v);
        return v < 64'sd0 ? 64'sd0 : v;
    endfunction

endpackage

// File: rtl/l3_mac_unit.sv
// l3_mac_unit: time-shared multiply-accumulate and neuron finish stage.
// Ports: clk, rst (sync, active-high); clr/fin clear the accumulator,
// en adds x*w; y is the combinational finished neuron value
// (acc + bias<<<FRAC, optional rounding, >>>FRAC, saturate, ReLU if relu).
// Macro L3_MLP_ROUND_EN: add half an LSB before the shift (round half up);
// undefined gives truncation toward -inf.
module l3_mac_unit import l3_mlp_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int MAX_N = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    fin,
    input  logic                    relu,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] w,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] y
);
    localparam int ACC_W = acc_width(WIDTH, MAX_N);
    localparam int SW = ACC_W + 1;
`ifdef L3_MLP_ROUND_EN
    localparam logic signed [SW-1:0] RND = SW'(1) <<< (FRAC - 1);
`else
    localparam logic signed [SW-1:0] RND = '0;
`endif

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shd;
    longint sat;

    assign prod = x * w;
    assign sum = SW'(acc) + (SW'(b) <<< FRAC) + RND;
    assign shd = sum >>> FRAC;
    assign sat = sat_w(longint'(shd), WIDTH);
    assign y = WIDTH'(relu ? relu_clamp(sat) : sat);

    // FIN consumes the sum on the same edge, so it also clears for the next neuron.
    always_ff @(posedge clk) begin
        if (rst || clr || fin) acc <= '0;
        else if (en) acc <= acc + ACC_W'(prod);
    end

endmodule

// File: rtl/l3_mlp_seq.sv
// l3_mlp_seq: runtime-configurable serial MLP engine with one shared MAC.
// Ports: clk, rst (sync, active-high); start (level, sampled in IDLE);
// in_vec (lane i at [i*WIDTH +: WIDTH]); topo (field 0 = input size,
// field l = layer l size); cfg_we/cfg_addr/cfg_data write the weight/bias RAM
// while not busy; out_vec (registered final layer, unused lanes 0);
// busy (LOAD..OUT); done (held until start drops); err (invalid topology).
// Macro L3_MLP_ROUND_EN selects round-half-up in the MAC unit.
module l3_mlp_seq import l3_mlp_pkg::*; #(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 8,
    parameter int MAX_N      = 4,
    parameter int NUM_LAYERS = 8,
    parameter int SZW        = 3,
    parameter int AW         = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [MAX_N*WIDTH-1:0]        in_vec,
    input  logic [(NUM_LAYERS+1)*SZW-1:0] topo,
    input  logic                          cfg_we,
    input  logic [AW-1:0]                 cfg_addr,
    input  logic [WIDTH-1:0]              cfg_data,
    output logic [MAX_N*WIDTH-1:0]        out_vec,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);
    localparam int RAM_N = NUM_LAYERS * MAX_N * (MAX_N + 1);
    localparam int RAM_AW = $clog2(RAM_N);
    localparam int LW = $clog2(NUM_LAYERS + 1);
    localparam int IW = $clog2(MAX_N);

    state_t state;
    state_t state_n;
    logic [WIDTH-1:0] ram [RAM_N];
    logic [WIDTH-1:0] bufs [2][MAX_N];
    logic [SZW-1:0] sz [NUM_LAYERS+1];
    logic [LW-1:0] l;
    logic [SZW-1:0] j;
    logic [SZW-1:0] i;
    logic [SZW-1:0] n_in;
    logic [SZW-1:0] n_out;
    logic sel;
    logic bad;
    logic last_i;
    logic last_j;
    logic last_l;
    logic [RAM_AW-1:0] w_a;
    logic [RAM_AW-1:0] b_a;
    logic signed [WIDTH-1:0] y;

    always_comb begin
        bad = 1'b0;
        for (int k = 0; k <= NUM_LAYERS; k++) begin
            sz[k] = topo[k*SZW +: SZW];
            bad = bad | (sz[k] == '0) | (int'(sz[k]) > MAX_N);
        end
    end

    assign n_in = sz[l - LW'(1)];
    assign n_out = sz[l];
    assign last_i = i == n_in - SZW'(1);
    assign last_j = j == n_out - SZW'(1);
    assign last_l = l == LW'(NUM_LAYERS);
    assign w_a = RAM_AW'(l3_mlp_pkg::cfg_addr(int'(l), int'(j), int'(i), MAX_N));
    assign b_a = RAM_AW'(l3_mlp_pkg::cfg_addr(int'(l), int'(j), MAX_N, MAX_N));
    assign busy = state inside {S_LOAD, S_MAC, S_FIN, S_OUT};
    assign done = state == S_DONE;

    l3_mac_unit #(
        .WIDTH(WIDTH),
        .FRAC (FRAC),
        .MAX_N(MAX_N)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (state == S_LOAD),
        .en  (state == S_MAC),
        .fin (state == S_FIN),
        .relu(!last_l),
        .x   (bufs[sel][i[IW-1:0]]),
        .w   (ram[w_a]),
        .b   (ram[b_a]),
        .y   (y)
    );

    // An invalid topology still passes through OUT so done lands one edge later,
    // matching the two-edge error turnaround; OUT emits zeros when err is set.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = start ? S_CHECK : S_IDLE;
            S_CHECK: state_n = bad ? S_OUT : S_LOAD;
            S_LOAD:  state_n = S_MAC;
            S_MAC:   state_n = last_i ? S_FIN : S_MAC;
            S_FIN:   state_n = last_j && last_l ? S_OUT : S_MAC;
            S_OUT:   state_n = S_DONE;
            S_DONE:  state_n = start ? S_DONE : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cfg_we && !busy && int'(cfg_addr) < RAM_N) ram[RAM_AW'(cfg_addr)] <= cfg_data;
    end

    // Buffer 0 is loaded from in_vec; each layer reads bufs[sel] and writes the other.
    always_ff @(posedge clk) begin
        if (state == S_LOAD) begin
            for (int k = 0; k < MAX_N; k++) bufs[0][IW'(k)] <= k < int'(sz[0]) ? in_vec[k*WIDTH +: WIDTH] : '0;
        end else if (state == S_FIN) begin
            bufs[~sel][j[IW-1:0]] <= y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            out_vec <= '0;
            err <= 1'b0;
            l <= LW'(1);
            j <= '0;
            i <= '0;
            sel <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_CHECK) begin
                err <= bad;
                if (bad) out_vec <= '0;
            end
            if (state == S_LOAD) begin
                l <= LW'(1);
                j <= '0;
                i <= '0;
                sel <= 1'b0;
            end
            if (state == S_MAC) i <= last_i ? '0 : i + SZW'(1);
            if (state == S_FIN) begin
                j <= last_j ? '0 : j + SZW'(1);
                l <= last_j && !last_l ? l + LW'(1) : l;
                sel <= last_j ? ~sel : sel;
            end
            if (state == S_OUT) begin
                for (int k = 0; k < MAX_N; k++) out_vec[k*WIDTH +: WIDTH] <= !err && k < int'(sz[NUM_LAYERS]) ? bufs[sel][IW'(k)] : '0;
            end
        end
    end

endmodule
